// File: rtl/preg_pkg.sv
// -----------------------------------------------------------------------------
// preg_pkg
// Shared types and constants for the physical-register allocation controller.
//   PREG_W / N_PREG : tag width and number of physical registers
//   N_LANES         : number of retire and recovery lanes
//   preg_t          : one physical register tag
//   pf_state_t      : prefetch buffer occupancy state (encoding equals count)
//   count_below()   : number of set bits in v below position idx
// -----------------------------------------------------------------------------
package preg_pkg;

  localparam int PREG_W  = 6;
  localparam int N_PREG  = 32;
  localparam int N_LANES = 2;

  typedef logic [PREG_W-1:0] preg_t;

  // The encoding is the number of buffered tags, so the state doubles as pf_cnt.
  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_ONE   = 2'd1,
    PF_TWO   = 2'd2
  } pf_state_t;

  // Used to compact the four return lanes: a lane's slot is the number of
  // valid lanes ahead of it. count_below(v, 4) gives the total.
  function automatic logic [2:0] count_below(input logic [3:0] v, input int idx);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < idx) c = c + 3'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/preg_alloc_ctrl_if.sv
// -----------------------------------------------------------------------------
// preg_alloc_ctrl_if
// Bundles the rename, retire, recovery and free-pool signals of the allocation
// controller.
//   slave  : the controller side (preg_alloc_ctrl)
//   master : the environment side (rename, retire, recovery, free pool)
// Rename  : alloc_valid, alloc_need -> alloc_ready, alloc_preg0/1, alloc_starved
// Retire  : ret_valid[1:0], ret_preg0/1 (always accepted)
// Recover : rec_valid[1:0], rec_preg0/1 -> rec_ready
// Pool    : pool_pop, pool_push1/2, pool_data_in1/2 <- pool_data_out, pool_empty
// -----------------------------------------------------------------------------
interface preg_alloc_ctrl_if;
  import preg_pkg::*;

  logic       alloc_valid;
  logic [1:0] alloc_need;
  logic       alloc_ready;
  preg_t      alloc_preg0;
  preg_t      alloc_preg1;
  logic       alloc_starved;

  logic [1:0] ret_valid;
  preg_t      ret_preg0;
  preg_t      ret_preg1;

  logic [1:0] rec_valid;
  preg_t      rec_preg0;
  preg_t      rec_preg1;
  logic       rec_ready;

  logic       pool_pop;
  preg_t      pool_data_out;
  logic       pool_empty;
  logic       pool_push1;
  logic       pool_push2;
  preg_t      pool_data_in1;
  preg_t      pool_data_in2;

  modport slave (
    input  alloc_valid, alloc_need,
    input  ret_valid, ret_preg0, ret_preg1,
    input  rec_valid, rec_preg0, rec_preg1,
    input  pool_data_out, pool_empty,
    output alloc_ready, alloc_preg0, alloc_preg1, alloc_starved,
    output rec_ready,
    output pool_pop, pool_push1, pool_push2, pool_data_in1, pool_data_in2
  );

  modport master (
    output alloc_valid, alloc_need,
    output ret_valid, ret_preg0, ret_preg1,
    output rec_valid, rec_preg0, rec_preg1,
    output pool_data_out, pool_empty,
    input  alloc_ready, alloc_preg0, alloc_preg1, alloc_starved,
    input  rec_ready,
    input  pool_pop, pool_push1, pool_push2, pool_data_in1, pool_data_in2
  );

endinterface

// File: rtl/release_fifo.sv
// -----------------------------------------------------------------------------
// release_fifo
// Circular queue of returned tags: up to four writes per cycle (valid lanes
// are packed in lane order, lane 0 first) and up to two reads per cycle.
// Reads are taken whenever entries exist, because the pool always accepts.
//   clk, rst            : clock, synchronous active-high reset
//   enq_valid_i[3:0]    : lane valids, {rec1, rec0, ret1, ret0}
//   enq_data_i[4]       : lane tags, same order
//   deq1_o / deq2_o     : head / head+1 leaving this cycle
//   deq_data1_o/2_o     : their tags (0 when not leaving)
//   count_o             : registered occupancy
// -----------------------------------------------------------------------------
module release_fifo
  import preg_pkg::*;
#(
  parameter int RQ_DEPTH = 8,
  localparam int AW = $clog2(RQ_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  enq_valid_i,
  input  preg_t       enq_data_i [4],
  output logic        deq1_o,
  output logic        deq2_o,
  output preg_t       deq_data1_o,
  output preg_t       deq_data2_o,
  output logic [AW:0] count_o
);

  preg_t         mem_q [RQ_DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   cnt_q;

  logic [2:0]    slot [4];
  logic [2:0]    n_enq;
  logic [1:0]    n_deq;
  logic [AW-1:0] head_p1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot[gi] = count_below(enq_valid_i, gi);
  end

  assign n_enq   = count_below(enq_valid_i, 4);
  assign deq1_o  = (cnt_q != '0);
  assign deq2_o  = (cnt_q >= (AW+1)'(2));
  assign n_deq   = deq2_o ? 2'd2 : {1'b0, deq1_o};
  assign head_p1 = head_q + AW'(1);

  assign deq_data1_o = deq1_o ? mem_q[head_q]  : '0;
  assign deq_data2_o = deq2_o ? mem_q[head_p1] : '0;
  assign count_o     = cnt_q;

  // Storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (enq_valid_i[k]) mem_q[tail_q + AW'(slot[k])] <= enq_data_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Recovery is throttled upstream so retire alone can never overflow.
      assert (int'(cnt_q) + int'(n_enq) - int'(n_deq) <= RQ_DEPTH);
      head_q <= head_q + AW'(n_deq);
      tail_q <= tail_q + AW'(n_enq);
      cnt_q  <= cnt_q + (AW+1)'(n_enq) - (AW+1)'(n_deq);
    end
  end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// preg_alloc_ctrl
// Sits between rename and the physical-register free pool. A two-entry
// prefetch buffer is topped up from the pool one tag per cycle so rename can
// take 0..2 tags per cycle. Retire and recovery returns are merged into a
// release queue that drains into the pool's two push lanes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : preg_alloc_ctrl_if.slave (rename, retire, recovery, pool)
// Parameter RQ_DEPTH: release queue depth (power of 2, >= 4).
// -----------------------------------------------------------------------------
module preg_alloc_ctrl
  import preg_pkg::*;
#(
  parameter int RQ_DEPTH = 8,
  localparam int AW = $clog2(RQ_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  preg_alloc_ctrl_if.slave       bus
);

  // ---------------- prefetch FSM and grant ----------------
  pf_state_t  state_q, state_d;
  preg_t      pf_q [2];
  preg_t      pf_d [2];
  logic [1:0] pf_cnt;
  logic [1:0] consume;
  logic [1:0] remain;
  logic [1:0] cnt_next;
  logic       pop;
  logic       ready;

  assign pf_cnt = state_q;

  always_comb begin
    state_d  = state_q;
    pf_d     = pf_q;
    pop      = 1'b0;
    ready    = 1'b0;
    consume  = 2'd0;
    remain   = 2'd0;
    cnt_next = 2'd0;

    // Pop and grant depend only on registered occupancy, never on alloc_*
    // into pop, and never on same-cycle pool data into grant.
    pop     = !rst && !bus.pool_empty && (state_q != PF_TWO);
    ready   = !rst && bus.alloc_valid && (bus.alloc_need <= pf_cnt);
    consume = ready ? bus.alloc_need : 2'd0;
    remain  = pf_cnt - consume;

    // Consume from the head first, then append the popped tag behind what is
    // left. A pop only happens with at most one entry left, so remain is 0/1.
    if (consume == 2'd1) pf_d[0] = pf_q[1];
    if (pop) pf_d[remain[0]] = bus.pool_data_out;

    cnt_next = remain + {1'b0, pop};
    unique case (cnt_next)
      2'd0:    state_d = PF_EMPTY;
      2'd1:    state_d = PF_ONE;
      default: state_d = PF_TWO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PF_EMPTY;
      pf_q[0] <= '0;
      pf_q[1] <= '0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
    end
  end

  assign bus.pool_pop      = pop;
  assign bus.alloc_ready   = ready;
  assign bus.alloc_starved = bus.alloc_valid && !ready;
  assign bus.alloc_preg0   = pf_q[0];
  assign bus.alloc_preg1   = pf_q[1];

  // ---------------- release queue ----------------
  logic [AW:0] rq_cnt;
  logic        rec_ok;
  logic [3:0]  enq_valid;
  preg_t       enq_data [4];
  logic        deq1;
  logic        deq2;
  preg_t       deq_data1;
  preg_t       deq_data2;

  // With rq_cnt <= DEPTH-4 all four lanes fit even before the drain.
  assign rec_ok    = (rq_cnt <= (AW+1)'(RQ_DEPTH - 4));
  assign enq_valid = {bus.rec_valid & {N_LANES{rec_ok}}, bus.ret_valid};
  assign enq_data[0] = bus.ret_preg0;
  assign enq_data[1] = bus.ret_preg1;
  assign enq_data[2] = bus.rec_preg0;
  assign enq_data[3] = bus.rec_preg1;

  release_fifo #(.RQ_DEPTH(RQ_DEPTH)) u_release_fifo (
    .clk         (clk),
    .rst         (rst),
    .enq_valid_i (enq_valid),
    .enq_data_i  (enq_data),
    .deq1_o      (deq1),
    .deq2_o      (deq2),
    .deq_data1_o (deq_data1),
    .deq_data2_o (deq_data2),
    .count_o     (rq_cnt)
  );

  assign bus.rec_ready     = rec_ok;
  assign bus.pool_push1    = !rst && deq1;
  assign bus.pool_push2    = !rst && deq2;
  assign bus.pool_data_in1 = rst ? '0 : deq_data1;
  assign bus.pool_data_in2 = rst ? '0 : deq_data2;

endmodule
